encoder_n_pipe: RTL and testbench
=================================

// Module: encoder_n_pipe
// PURPOSE
// - Parametrised N-to-log2(N) encoder with one registered output stage and valid/ready handshake on both sides.
// - Four run-time modes: normal (one-hot only), high-priority, low-priority, round-robin.
// - Flags every beat whose code is invalid and keeps a saturating error count.
// - Sits between request sources (keys, IRQ lines, FIFO-nonempty flags) and a downstream consumer that may stall.
// PARAMETERS
// - N      10               number of input lines, 2..64
// - W      $clog2(N)        code width (derived, do not override)
// - ERR_W  8                width of the saturating error counter
// PORTS
// - clk        in   1      clock, rising edge
// - rst        in   1      reset; asynchronous and active-high
// - en         in   1      block enable; 0 blocks new acceptance
// - mode_sel   in   2      00 normal, 01 priority-high, 10 priority-low, 11 round-robin
// - din        in   N      request lines
// - din_valid  in   1      din/mode_sel are valid this cycle
// - din_ready  out  1      block can accept this cycle
// - dout       out  W      encoded index
// - dout_ok    out  1      1 = dout is a valid code; 0 = invalid beat
// - dout_valid out  1      output beat present
// - dout_ready in   1      consumer takes beat this cycle
// - err_cnt    out  ERR_W  number of accepted beats with dout_ok=0, saturating
// BEHAVIOUR
// - Reset (async assert): dout=0, dout_ok=0, dout_valid=0, err_cnt=0, rr_ptr=0. Deassertion is synchronous to clk.
// - din_ready = en & (~dout_valid | dout_ready). Combinational; no dependence on din_valid.
// - Accept = din_valid & din_ready. mode_sel and din are sampled only at accept. Latency is 1 cycle, accept to dout_valid.
// - Output register: on accept it loads {dout, dout_ok} and sets dout_valid=1. Without accept, dout_valid clears when dout_ready=1; otherwise it holds.
// - Simultaneous consume and accept: the new beat replaces the old one and dout_valid stays 1 (full throughput).
// - While dout_valid=1 and dout_ready=0, dout, dout_ok and dout_valid stay stable.
// - Normal mode: popcount(din)==1 gives dout = index, ok=1. Any other popcount gives dout=0, ok=0.
// - Priority-high: dout = highest set index, ok=1. Priority-low: dout = lowest set index, ok=1.
// - Round-robin: dout = first set index found searching rr_ptr, rr_ptr+1, ... N-1, 0, ... (wraps), ok=1.
//   - On that accept rr_ptr <= (dout==N-1) ? 0 : dout+1.
//   - rr_ptr changes only on round-robin accepts with ok=1.
// - Any mode with din==0: dout=0, ok=0.
// - err_cnt increments on each accept with ok=0 and saturates at 2^ERR_W-1 (no wrap).
// - en deasserted while a beat is held: the beat stays until consumed; only acceptance is blocked.
// - Asynchronous reset mid-operation discards any held beat immediately.
// - mode_sel changes between beats are legal. rr_ptr is kept across mode changes.
// - Width rule: indices are compared and emitted as W-bit unsigned. rr_ptr is W bits and always < N.
// STRUCTURE
// - Package enc_pkg:
//   - typedef enum logic[1:0] enc_mode_e {ENC_NORMAL, ENC_PRIO_HI, ENC_PRIO_LO, ENC_RR}
//   - localparam ENC_MAX_N=64
//   - function onehot_chk(din) returning popcount==1
// - Sub-module enc_prio_core #(N): combinational; inputs din, start_idx, dir; outputs idx, found.
//   - Instanced once; start_idx and dir are muxed from the mode.
//   - Priority-high uses dir=down, start=N-1. Priority-low and RR use dir=up, start=0 / rr_ptr.
// - Top level holds the output register, handshake logic, rr_ptr and err_cnt.
// TESTING
// - N=10, normal mode, din=10'b00_0010_0000, dout_ready=1 -> next cycle dout=5, ok=1, valid=1; err_cnt=0.
// - Normal mode, din=10'b10_0000_0100 -> dout=0, ok=0, err_cnt=1.
//   - Feed 300 such beats -> err_cnt saturates at 255.
// - Priority-high then priority-low, din=10'b01_0001_0010 -> dout=8 then dout=1, both ok=1.
// - Round-robin, din=10'b10_0000_0011 held for 4 beats -> dout sequence 0,1,9,0; rr_ptr wraps 9->0.
// - Backpressure: dout_ready=0 for 5 cycles after beat A -> dout stable, din_ready=0.
//   - Then dout_ready=1 with din_valid=1 -> beat B loads the same cycle, no bubble.
// - Reset mid-stream, and en=0: assert rst while dout_valid=1 -> dout_valid=0, rr_ptr=0 immediately.
//   - With en=0 -> din_ready=0 and the held beat still drains.
// - Random: all 4 modes, N in {2,10,16,33}, random valid/ready.
//   - Scoreboard against a reference model. Assert: dout < N when ok=1; no beat lost or duplicated.

Source files
------------

// File: rtl/enc_pkg.sv
// enc_pkg: shared mode encoding, limits and helpers for the pipelined N-line encoder
package enc_pkg;
  typedef enum logic [1:0] {ENC_NORMAL, ENC_PRIO_HI, ENC_PRIO_LO, ENC_RR} enc_mode_e;
  localparam int ENC_MAX_N = 64;
  function automatic logic onehot_chk(input logic [ENC_MAX_N-1:0] v);
    return $countones(v) == 1;
  endfunction
endpackage

// File: rtl/enc_prio_core.sv
// enc_prio_core: circular first-set search from start_idx, upward or downward
module enc_prio_core #(
  parameter int N = 10,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] din,
  input  logic [W-1:0] start_idx,
  input  logic         dir,
  output logic [W-1:0] idx,
  output logic         found
);
  function automatic logic [W-1:0] pos(input int s, input int k, input logic d);
    int q;
    q = d ? s - k : s + k;
    q = q < 0 ? q + N : q >= N ? q - N : q;
    return W'(q);
  endfunction
  // scanning the distance from far to near lets the nearest set line win
  always_comb begin
    idx = '0;
    found = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (din[pos(int'(start_idx), k, dir)]) begin
        idx = pos(int'(start_idx), k, dir);
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/encoder_n_pipe.sv
// encoder_n_pipe: N-to-log2(N) multi-mode encoder with one registered valid/ready stage
module encoder_n_pipe
  import enc_pkg::*;
#(
  parameter int N     = 10,
  parameter int W     = $clog2(N),
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode_sel,
  input  logic [N-1:0]     din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic [W-1:0]     dout,
  output logic             dout_ok,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic [ERR_W-1:0] err_cnt
);
  enc_mode_e mode;
  logic [W-1:0] rr_ptr, start_idx, idx;
  logic dir, found, acc, nxt_ok;
  assign mode = enc_mode_e'(mode_sel);
  assign dir = mode == ENC_PRIO_HI;
  assign start_idx = dir ? W'(N - 1) : mode == ENC_RR ? rr_ptr : '0;
  enc_prio_core #(.N(N), .W(W)) u_core (
    .din(din),
    .start_idx(start_idx),
    .dir(dir),
    .idx(idx),
    .found(found)
  );
  assign din_ready = en & (~dout_valid | dout_ready);
  assign acc = din_valid & din_ready;
  // in normal mode a single set line is also the lowest one, so the core index is reused
  assign nxt_ok = mode == ENC_NORMAL ? onehot_chk(ENC_MAX_N'(din)) : found;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout <= '0;
      dout_ok <= 1'b0;
      dout_valid <= 1'b0;
      err_cnt <= '0;
      rr_ptr <= '0;
    end else if (acc) begin
      dout <= nxt_ok ? idx : '0;
      dout_ok <= nxt_ok;
      dout_valid <= 1'b1;
      if (!nxt_ok && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
      if (mode == ENC_RR && nxt_ok) rr_ptr <= idx == W'(N - 1) ? '0 : idx + 1'b1;
    end else if (dout_ready) begin
      dout_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_encoder_n_pipe.sv
// tb_encoder_n_pipe: directed scenarios on N=10 plus a randomized scoreboard across N=10,2,16,33
module tb_encoder_n_pipe;
  localparam int NS[4] = '{10, 2, 16, 33};
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, din_valid = 1'b0, dout_ready = 1'b0;
  logic [1:0] mode_sel = 2'd0;
  logic [63:0] din_w = '0;
  logic [3:0] dout0, dout2;
  logic [0:0] dout1;
  logic [5:0] dout3;
  logic ok0, ok1, ok2, ok3, vl0, vl1, vl2, vl3, rd0, rd1, rd2, rd3;
  logic [7:0] ec0, ec1, ec2, ec3;
  int vectors = 0, errs = 0;
  int sb[4][$];
  int rr_m[4], err_m[4], od[4];
  bit okv[4], vlv[4], rdv[4];
  int ecv[4];

  always #5 clk = ~clk;

  encoder_n_pipe #(.N(10)) dut0 (.clk(clk), .rst(rst), .en(en), .mode_sel(mode_sel), .din(din_w[9:0]),
    .din_valid(din_valid), .din_ready(rd0), .dout(dout0), .dout_ok(ok0), .dout_valid(vl0),
    .dout_ready(dout_ready), .err_cnt(ec0));
  encoder_n_pipe #(.N(2)) dut1 (.clk(clk), .rst(rst), .en(en), .mode_sel(mode_sel), .din(din_w[1:0]),
    .din_valid(din_valid), .din_ready(rd1), .dout(dout1), .dout_ok(ok1), .dout_valid(vl1),
    .dout_ready(dout_ready), .err_cnt(ec1));
  encoder_n_pipe #(.N(16)) dut2 (.clk(clk), .rst(rst), .en(en), .mode_sel(mode_sel), .din(din_w[15:0]),
    .din_valid(din_valid), .din_ready(rd2), .dout(dout2), .dout_ok(ok2), .dout_valid(vl2),
    .dout_ready(dout_ready), .err_cnt(ec2));
  encoder_n_pipe #(.N(33)) dut3 (.clk(clk), .rst(rst), .en(en), .mode_sel(mode_sel), .din(din_w[32:0]),
    .din_valid(din_valid), .din_ready(rd3), .dout(dout3), .dout_ok(ok3), .dout_valid(vl3),
    .dout_ready(dout_ready), .err_cnt(ec3));

  // reference encoder: bit 8 of the result is ok, bits 7:0 the index
  function automatic int ref_enc(input int n, input int mode, input logic [63:0] d, input int rr);
    if (d == 0 || (mode == 0 && $countones(d) != 1)) return 0;
    if (mode == 1) for (int i = n - 1; i >= 0; i--) if (d[i]) return 256 | i;
    if (mode == 3) for (int k = 0; k < n; k++) if (d[(rr + k) % n]) return 256 | ((rr + k) % n);
    for (int i = 0; i < n; i++) if (d[i]) return 256 | i;
    return 0;
  endfunction

  // scoreboard: pop on consume, then push on accept, both judged mid-cycle
  always @(negedge clk) begin
    od[0] = int'(dout0); od[1] = int'(dout1); od[2] = int'(dout2); od[3] = int'(dout3);
    okv = '{ok0, ok1, ok2, ok3};
    vlv = '{vl0, vl1, vl2, vl3};
    rdv = '{rd0, rd1, rd2, rd3};
    if (rst) begin
      for (int g = 0; g < 4; g++) begin sb[g].delete(); rr_m[g] = 0; err_m[g] = 0; end
    end else begin
      for (int g = 0; g < 4; g++) begin
        int e, got, r;
        logic [63:0] d;
        vectors++;
        if (rdv[g] !== (en & (~vlv[g] | dout_ready))) begin
          errs++; $display("FAIL sb_ready n=%0d got %0b exp %0b", NS[g], rdv[g], en & (~vlv[g] | dout_ready));
        end
        if (vlv[g] && dout_ready) begin
          vectors++;
          got = (okv[g] ? 256 : 0) | od[g];
          if (sb[g].size() == 0) begin
            errs++; $display("FAIL sb_extra_beat n=%0d got %0h exp none", NS[g], got);
          end else begin
            e = sb[g].pop_front();
            if (got !== e) begin errs++; $display("FAIL sb_beat n=%0d got %0h exp %0h", NS[g], got, e); end
          end
          if (okv[g] && od[g] >= NS[g]) begin errs++; $display("FAIL sb_range n=%0d got %0d exp <%0d", NS[g], od[g], NS[g]); end
        end
        if (din_valid && rdv[g]) begin
          d = din_w & ((64'd1 << NS[g]) - 64'd1);
          r = ref_enc(NS[g], int'(mode_sel), d, rr_m[g]);
          sb[g].push_back(r);
          if (!r[8]) err_m[g] = err_m[g] == 255 ? 255 : err_m[g] + 1;
          else if (mode_sel == 2'd3) rr_m[g] = (r & 255) == NS[g] - 1 ? 0 : (r & 255) + 1;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) cyc();
    vectors += 5;
    if (dout0 !== 4'd0) begin errs++; $display("FAIL rst_dout got %0d exp 0", dout0); end
    if (ok0 !== 1'b0) begin errs++; $display("FAIL rst_ok got %0b exp 0", ok0); end
    if (vl0 !== 1'b0) begin errs++; $display("FAIL rst_valid got %0b exp 0", vl0); end
    if (ec0 !== 8'd0) begin errs++; $display("FAIL rst_err got %0d exp 0", ec0); end
    if (dut0.rr_ptr !== 4'd0) begin errs++; $display("FAIL rst_rr got %0d exp 0", dut0.rr_ptr); end
    rst = 1'b0; en = 1'b1; dout_ready = 1'b1;
    #1 vectors++;
    if (rd0 !== 1'b1) begin errs++; $display("FAIL rst_ready got %0b exp 1", rd0); end
  endtask

  task automatic test_normal();
    mode_sel = 2'd0; din_w = 64'h020; din_valid = 1'b1;
    cyc(); din_valid = 1'b0;
    vectors += 4;
    if (dout0 !== 4'd5) begin errs++; $display("FAIL nrm_dout got %0d exp 5", dout0); end
    if (ok0 !== 1'b1) begin errs++; $display("FAIL nrm_ok got %0b exp 1", ok0); end
    if (vl0 !== 1'b1) begin errs++; $display("FAIL nrm_valid got %0b exp 1", vl0); end
    if (ec0 !== 8'd0) begin errs++; $display("FAIL nrm_err got %0d exp 0", ec0); end
    din_w = 64'h204; din_valid = 1'b1;
    cyc(); din_valid = 1'b0;
    vectors += 3;
    if (dout0 !== 4'd0) begin errs++; $display("FAIL bad_dout got %0d exp 0", dout0); end
    if (ok0 !== 1'b0) begin errs++; $display("FAIL bad_ok got %0b exp 0", ok0); end
    if (ec0 !== 8'd1) begin errs++; $display("FAIL bad_err got %0d exp 1", ec0); end
    cyc(); vectors++;
    if (vl0 !== 1'b0) begin errs++; $display("FAIL drain_valid got %0b exp 0", vl0); end
  endtask

  task automatic test_saturate();
    din_w = 64'h204; din_valid = 1'b1;
    repeat (300) cyc();
    din_valid = 1'b0;
    vectors++;
    if (ec0 !== 8'd255) begin errs++; $display("FAIL sat_err got %0d exp 255", ec0); end
    cyc();
  endtask

  task automatic test_priority();
    mode_sel = 2'd1; din_w = 64'h112; din_valid = 1'b1;
    cyc(); vectors += 2;
    if (dout0 !== 4'd8) begin errs++; $display("FAIL phi_dout got %0d exp 8", dout0); end
    if (ok0 !== 1'b1) begin errs++; $display("FAIL phi_ok got %0b exp 1", ok0); end
    mode_sel = 2'd2;
    cyc(); din_valid = 1'b0; vectors += 2;
    if (dout0 !== 4'd1) begin errs++; $display("FAIL plo_dout got %0d exp 1", dout0); end
    if (ok0 !== 1'b1) begin errs++; $display("FAIL plo_ok got %0b exp 1", ok0); end
    cyc();
  endtask

  task automatic test_round_robin();
    int exp_seq[4] = '{0, 1, 9, 0};
    mode_sel = 2'd3; din_w = 64'h203; din_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc(); vectors++;
      if (dout0 !== 4'(exp_seq[i]) || ok0 !== 1'b1) begin
        errs++; $display("FAIL rr_beat%0d got %0d/%0b exp %0d/1", i, dout0, ok0, exp_seq[i]);
      end
      if (i == 2) begin
        vectors++;
        if (dut0.rr_ptr !== 4'd0) begin errs++; $display("FAIL rr_wrap got %0d exp 0", dut0.rr_ptr); end
      end
    end
    din_valid = 1'b0;
    cyc();
  endtask

  task automatic test_back_to_back();
    mode_sel = 2'd2; din_w = 64'h008; din_valid = 1'b1;
    cyc();
    dout_ready = 1'b0; din_w = 64'h040;
    for (int i = 0; i < 5; i++) begin
      cyc(); vectors++;
      if (dout0 !== 4'd3 || vl0 !== 1'b1 || rd0 !== 1'b0) begin
        errs++; $display("FAIL stall%0d got dout=%0d v=%0b rdy=%0b exp dout=3 v=1 rdy=0", i, dout0, vl0, rd0);
      end
    end
    dout_ready = 1'b1;
    #1 vectors++;
    if (rd0 !== 1'b1) begin errs++; $display("FAIL b2b_ready got %0b exp 1", rd0); end
    cyc(); din_valid = 1'b0; vectors++;
    if (dout0 !== 4'd6 || vl0 !== 1'b1) begin errs++; $display("FAIL b2b_beat got %0d/%0b exp 6/1", dout0, vl0); end
    cyc();
  endtask

  task automatic test_reset_en();
    mode_sel = 2'd3; din_w = 64'h004; din_valid = 1'b1; dout_ready = 1'b0;
    cyc(); din_valid = 1'b0; vectors++;
    if (dout0 !== 4'd2 || vl0 !== 1'b1 || dut0.rr_ptr !== 4'd3) begin
      errs++; $display("FAIL hold_beat got %0d/%0b/%0d exp 2/1/3", dout0, vl0, dut0.rr_ptr);
    end
    #2 rst = 1'b1;
    #1 vectors++;
    if (vl0 !== 1'b0 || dut0.rr_ptr !== 4'd0 || ec0 !== 8'd0) begin
      errs++; $display("FAIL async_rst got v=%0b rr=%0d err=%0d exp 0/0/0", vl0, dut0.rr_ptr, ec0);
    end
    @(negedge clk);
    cyc(); rst = 1'b0;
    din_w = 64'h203; din_valid = 1'b1; dout_ready = 1'b1;
    cyc(); vectors++;
    if (dout0 !== 4'd0 || ok0 !== 1'b1) begin errs++; $display("FAIL rr_after_rst got %0d/%0b exp 0/1", dout0, ok0); end
    mode_sel = 2'd2; din_w = 64'h001; dout_ready = 1'b0;
    cyc();
    en = 1'b0;
    #1 vectors++;
    if (rd0 !== 1'b0) begin errs++; $display("FAIL en_ready got %0b exp 0", rd0); end
    cyc(); vectors++;
    if (vl0 !== 1'b1 || dout0 !== 4'd0) begin errs++; $display("FAIL en_hold got %0b/%0d exp 1/0", vl0, dout0); end
    dout_ready = 1'b1;
    cyc(); vectors++;
    if (vl0 !== 1'b0 || rd0 !== 1'b0) begin errs++; $display("FAIL en_drain got v=%0b rdy=%0b exp 0/0", vl0, rd0); end
    en = 1'b1; din_valid = 1'b0;
    cyc();
  endtask

  task automatic test_random();
    int sel;
    for (int i = 0; i < 3000; i++) begin
      en = $urandom_range(9) != 0;
      din_valid = 1'($urandom_range(1));
      dout_ready = $urandom_range(3) != 0;
      mode_sel = 2'($urandom_range(3));
      sel = $urandom_range(3);
      din_w = sel == 0 ? 64'd0 : sel == 1 ? 64'd1 << $urandom_range(63) :
              sel == 2 ? (64'd1 << $urandom_range(33)) | (64'd1 << $urandom_range(33)) : {$urandom, $urandom};
      cyc();
    end
    din_valid = 1'b0; dout_ready = 1'b1; en = 1'b1;
    repeat (3) cyc();
    ecv = '{int'(ec0), int'(ec1), int'(ec2), int'(ec3)};
    for (int g = 0; g < 4; g++) begin
      vectors += 2;
      if (sb[g].size() != 0) begin errs++; $display("FAIL rnd_lost n=%0d got %0d pending exp 0", NS[g], sb[g].size()); end
      if (ecv[g] != err_m[g]) begin errs++; $display("FAIL rnd_err n=%0d got %0d exp %0d", NS[g], ecv[g], err_m[g]); end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_normal();
    test_saturate();
    test_priority();
    test_round_robin();
    test_back_to_back();
    test_reset_en();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
